// File: rtl/rf_access_ctrl.sv
// Register-file access controller.
// Serialises single-beat write and read commands onto an external 8x32
// register file and can sweep every register to a fixed clear value.
// A read goes through a one-cycle READ state so the file's combinational
// read data is captured into a held response until the consumer takes it.
module rf_access_ctrl #(
   parameter logic [31:0] CLR_VALUE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [2:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic        clr_start,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [2:0]  rf_raddr,
   input  logic [31:0] rf_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic        clr_done,
   output logic [7:0]  op_count
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      RESP,
      CLEAR
   } stateT;

   stateT state;

   // Commands are only taken in IDLE, and a pending clear request wins the cycle
   assign cmd_ready = (state == IDLE) && !clr_start && !reset;

   // Anything other than IDLE means an operation is in flight
   assign busy = (state != IDLE);

   // Main controller: next state plus every registered output.
   // rf_we and clr_done default low each cycle so they are pulses unless a
   // state explicitly keeps them up.  During a clear sweep rf_waddr doubles
   // as the sweep counter, loaded with 0 when the sweep starts.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rf_we     <= 1'b0;
         rf_waddr  <= 3'd0;
         rf_wdata  <= 32'd0;
         rf_raddr  <= 3'd0;
         rsp_valid <= 1'b0;
         rsp_data  <= 32'd0;
         clr_done  <= 1'b0;
         op_count  <= 8'd0;
      end else begin
         rf_we    <= 1'b0;
         clr_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (clr_start) begin
                  state    <= CLEAR;
                  rf_we    <= 1'b1;
                  rf_waddr <= 3'd0;
                  rf_wdata <= CLR_VALUE;
               end else if (cmd_valid) begin
                  if (cmd_write) begin
                     state    <= WRITE;
                     rf_we    <= 1'b1;
                     rf_waddr <= cmd_addr;
                     rf_wdata <= cmd_wdata;
                  end else begin
                     state    <= READ;
                     rf_raddr <= cmd_addr;
                  end
               end
            end
            WRITE: begin
               state    <= IDLE;
               op_count <= op_count + 8'd1;
            end
            READ: begin
               state     <= RESP;
               rsp_data  <= rf_rdata;
               rsp_valid <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 8'd1;
               end
            end
            CLEAR: begin
               if (rf_waddr == 3'd7) begin
                  state    <= IDLE;
                  clr_done <= 1'b1;
               end else begin
                  rf_we    <= 1'b1;
                  rf_waddr <= rf_waddr + 3'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/rf_access_ctrl.md
RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter CLR_VALUE, default 32'h0000_0000, data written to every register during a clear sweep.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  3  target register 0-7.
REQ-009 cmd_wdata  input  32  write data; ignored for reads.
REQ-010 clr_start  input  1  request to sweep all 8 registers to CLR_VALUE.
REQ-011 rf_we  output  1  register-file write enable.
REQ-012 rf_waddr  output  3  register-file write address.
REQ-013 rf_wdata  output  32  register-file write data.
REQ-014 rf_raddr  output  3  register-file read address.
REQ-015 rf_rdata  input  32  register-file read data; combinational from rf_raddr.
REQ-016 rsp_valid  output  1  read response available.
REQ-017 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-018 rsp_data  output  32  read response data.
REQ-019 busy  output  1  high whenever FSM is not IDLE.
REQ-020 clr_done  output  1  one-cycle pulse on clear completion.
REQ-021 op_count  output  8  completed write + read commands, wraps 255->0; clear sweeps not counted.

Function
REQ-022 FSM states SHALL be IDLE, WRITE, READ, RESP and CLEAR; all outputs except cmd_ready and busy are registered.
REQ-023 cmd_ready SHALL be 1 only in IDLE with clr_start low and reset low.
REQ-024 In IDLE, clr_start high SHALL take priority over cmd_valid; the FSM goes to CLEAR, no command is accepted that cycle, and the clear-address counter loads 0.
REQ-025 Accepted write: cmd_addr/cmd_wdata latched, next state WRITE; in WRITE, rf_we=1, rf_waddr/rf_wdata = latched values for exactly one cycle; then IDLE, op_count+1.
REQ-026 Write latency: rf_we SHALL be high in the cycle immediately following acceptance.
REQ-027 Accepted read: rf_raddr = cmd_addr from the next cycle; state READ for one cycle; rf_rdata captured into rsp_data at the end of READ; next state RESP.
REQ-028 RESP: rsp_valid=1, rsp_data stable until rsp_ready; on handshake rsp_valid drops next cycle, state IDLE, op_count+1.
REQ-029 Read-after-write to the same address SHALL return the newly written data, because the write completes before the read is accepted.
REQ-030 CLEAR: 8 consecutive cycles with rf_we=1, rf_wdata=CLR_VALUE, rf_waddr=0,1,...,7; after address 7, state IDLE and clr_done=1 for one cycle.
REQ-031 clr_start and cmd_valid SHALL be ignored outside IDLE; no queuing.
REQ-032 rf_we SHALL be 0 in IDLE, READ and RESP.
REQ-033 rf_raddr SHALL hold its last value when not in READ.

Reset
REQ-034 While reset is high at a clock edge: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr=0, rsp_valid=0, rsp_data=0, clr_done=0, op_count=0, cmd_ready=0, busy=0.
REQ-035 Reset mid-WRITE, mid-CLEAR or in RESP SHALL abort the operation in that same cycle with no further rf_we and no clr_done; the pending response is discarded.
REQ-036 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-037 Write addr 3 data 32'hDEAD_BEEF, then read addr 3 -> rf_we one cycle after acceptance; rsp_data=32'hDEAD_BEEF; op_count=2.
REQ-038 Read with rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable 5 cycles; cmd_ready=0 throughout; IDLE one cycle after handshake.
REQ-039 clr_start and cmd_valid asserted together in IDLE -> CLEAR entered, command not accepted; rf_waddr 0..7 over 8 cycles; clr_done pulse; reading each register returns CLR_VALUE.
REQ-040 Reset asserted during clear cycle 4 -> rf_we=0 next cycle, no clr_done, all outputs at reset values.
REQ-041 256 completed writes -> op_count wraps to 0.
REQ-042 clr_start pulsed during RESP -> ignored; no clear sweep after returning to IDLE.
